// File: rtl/tt_multiplier.sv
// TinyTapeout tile: byte-serial 8x8 shift-add multiplier with signed/unsigned mode.
// Operands are loaded through ui_in, the product is read back a byte at a time.
module tt_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [PW-1:0]     p_q, acc_q, mcand_q;
  logic [WIDTH-1:0]  mplr_q;
  logic [CW-1:0]     cnt_q;
  logic              sign_q, busy_q, done_q, start_q;

  logic              ld_a, ld_b, start_in, sel_hi, smode;
  logic              start_edge, accept, step, finish, ld_ok;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic              unused_ok;

  assign ld_a     = uio_in[0];
  assign ld_b     = uio_in[1];
  assign start_in = uio_in[2];
  assign sel_hi   = uio_in[3];
  assign smode    = ui_in[0];
  assign unused_ok = &{1'b0, uio_in[7:4]};

  assign start_edge = start_in & ~start_q;

  // The magnitude of the most negative operand is 2^(WIDTH-1), which still
  // fits an unsigned WIDTH-bit value, so no extra magnitude bit is needed.
  always_comb begin
    mag_a = a_q;
    mag_b = b_q;
    if (smode && a_q[WIDTH-1]) mag_a = ~a_q + WIDTH'(1);
    if (smode && b_q[WIDTH-1]) mag_b = ~b_q + WIDTH'(1);
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          accept  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FINISH;
      end
      S_FINISH: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A start edge takes priority over a coincident load.
  assign ld_ok = (state_q == S_IDLE) && !start_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else if (ena) state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
    end else if (ena) begin
      start_q <= start_in;
      if (accept) begin
        sign_q  <= smode & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        acc_q   <= '0;
        mcand_q <= PW'(mag_a);
        mplr_q  <= mag_b;
        cnt_q   <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if (ld_ok && (ld_a || ld_b)) begin
        if (ld_a) a_q <= ui_in[WIDTH-1:0];
        if (ld_b) b_q <= ui_in[WIDTH-1:0];
        done_q <= 1'b0;
      end
      if (step) begin
        if (mplr_q[0]) acc_q <= acc_q + mcand_q;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
        cnt_q   <= cnt_q + CW'(1);
      end
      if (finish) begin
        p_q    <= sign_q ? -acc_q : acc_q;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign uo_out  = sel_hi ? p_q[PW-1 -: 8] : p_q[7:0];
  assign uio_out = {p_q[PW-1], (p_q == '0), done_q, busy_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_multiplier.sv
// Bench for tt_multiplier: directed spec cases plus randomized operands
// checked against an integer-arithmetic product model.
module tb_tt_multiplier;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_p = 16'h0000;

  tt_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic mode);
    int r;
    if (mode) r = int'($signed(a)) * int'($signed(b));
    else      r = int'(a) * int'(b);
    return r[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    uio_in = 8'h01; ui_in = a; tick();
    uio_in = 8'h02; ui_in = b; tick();
    uio_in = 8'h00;
  endtask

  task automatic start_pulse(input logic mode);
    ui_in = {7'b0, mode};
    uio_in = 8'h04;
    tick();
    uio_in = 8'h00;
  endtask

  task automatic read_p(input string tag);
    uio_in[3] = 1'b0; #1;
    chk({tag, " lo"}, uo_out, exp_p[7:0]);
    uio_in[3] = 1'b1; #1;
    chk({tag, " hi"}, uo_out, exp_p[15:8]);
    uio_in[3] = 1'b0; #1;
    chk({tag, " flags"}, uio_out[7:6], {exp_p[15], exp_p == 16'h0});
  endtask

  // Counts edges until done, bounded; a timeout shows up as a wrong count.
  task automatic wait_done(input string tag, input int exp_k);
    int k = 0;
    while (uio_out[5] !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk({tag, " latency"}, k, exp_k);
  endtask

  task automatic run_exact(input logic [7:0] a, input logic [7:0] b, input logic mode,
                           input string tag);
    logic [15:0] prev;
    load(a, b);
    chk({tag, " done cleared by load"}, uio_out[5], 1'b0);
    prev = exp_p;
    start_pulse(mode);
    chk({tag, " busy at N"}, uio_out[5:4], 2'b01);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk({tag, " busy in calc"}, uio_out[5:4], 2'b01);
    end
    chk({tag, " old P in calc"}, uo_out, prev[7:0]);
    tick();
    chk({tag, " done at N+9"}, uio_out[5:4], 2'b10);
    exp_p = model(a, b, mode);
    read_p(tag);
  endtask

  initial begin
    int rises;
    logic prevb;
    logic [7:0] ra, rb;
    logic rm;

    #2;
    chk("reset uo_out", uo_out, 8'h00);
    chk("reset uio_out", uio_out, 8'h40);
    chk("reset uio_oe", uio_oe, 8'hF0);
    #11 rst_n = 1'b1;
    tick();

    run_exact(8'd200, 8'd150, 1'b0, "unsigned 200x150");
    run_exact(8'hFD, 8'h05, 1'b1, "signed -3x5");
    run_exact(8'h80, 8'h80, 1'b1, "signed -128x-128");
    run_exact(8'hFF, 8'hFF, 1'b0, "unsigned 255x255");
    run_exact(8'h80, 8'h7F, 1'b1, "signed -128x127");
    run_exact(8'h00, 8'hA5, 1'b1, "zero operand");

    // Held start: exactly one operation.
    load(8'd7, 8'd9);
    ui_in = 8'h00;
    uio_in = 8'h04;
    rises = 0;
    prevb = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (uio_out[4] && !prevb) rises++;
      prevb = uio_out[4];
    end
    uio_in = 8'h00;
    chk("held start ops", rises, 1);
    chk("held start done", uio_out[5:4], 2'b10);
    exp_p = model(8'd7, 8'd9, 1'b0);
    read_p("held start");

    // Start re-pulse and ld_a while busy are both ignored.
    load(8'h12, 8'h34);
    start_pulse(1'b0);
    tick();
    uio_in = 8'h05; ui_in = 8'hFF;
    tick();
    uio_in = 8'h00;
    wait_done("busy repulse", 7);
    exp_p = model(8'h12, 8'h34, 1'b0);
    read_p("busy repulse");
    start_pulse(1'b0);
    wait_done("A kept", 9);
    read_p("A kept");

    // Load and start together: previous operands used.
    ui_in = 8'h00; uio_in = 8'h07;
    tick();
    uio_in = 8'h00;
    wait_done("load+start", 9);
    read_p("load+start");

    // Reset mid-calc aborts at once.
    load(8'h55, 8'h66);
    start_pulse(1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("abort uio_out", uio_out, 8'h40);
    chk("abort uo_out", uo_out, 8'h00);
    exp_p = 16'h0000;
    #2 rst_n = 1'b1;
    tick();

    // ena low for 5 cycles mid-calc delays done by 5.
    load(8'h9C, 8'h2B);
    start_pulse(1'b1);
    repeat (3) tick();
    ena = 1'b0;
    repeat (5) tick();
    chk("freeze busy", uio_out[5:4], 2'b01);
    chk("freeze P", uo_out, 8'h00);
    ena = 1'b1;
    wait_done("freeze", 6);
    exp_p = model(8'h9C, 8'h2B, 1'b1);
    read_p("freeze");

    for (int i = 0; i < 25; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rm = 1'($urandom_range(0, 1));
      load(ra, rb);
      start_pulse(rm);
      wait_done("random", 9);
      exp_p = model(ra, rb, rm);
      read_p($sformatf("random %02h*%02h m%0d", ra, rb, rm));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
